fft_bitrev_reorder: RTL and testbench



---
 rtl/fft_bitrev_reorder.sv | 174 +++++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder
// Output-reorder stage for the FFT. Input samples arrive in bit-reversed index
// order. Each frame of N = 2^logn complex samples is buffered in one bank of a
// ping-pong memory, then re-emitted in natural index order with a frame-last
// marker. Both sides run at up to one sample per cycle with no backpressure.
//
// Read-side FSM
//   state  | meaning
//   S_IDLE | waiting for the bank at r_rd_bank to be marked full
//   S_READ | issuing one bit-reversed read per cycle from r_rd_bank
module fft_bitrev_reorder #(
    parameter int FLOAT_PRECISION = 64,
    parameter int logn            = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [FLOAT_PRECISION-1:0] di_re,
    input  logic [FLOAT_PRECISION-1:0] di_im,
    output logic                       out_valid,
    output logic                       out_last,
    output logic [logn-1:0]            out_idx,
    output logic [FLOAT_PRECISION-1:0] do_re,
    output logic [FLOAT_PRECISION-1:0] do_im
);

    localparam int              N       = 1 << logn;
    localparam int              DW      = 2 * FLOAT_PRECISION;
    localparam logic [logn-1:0] CNT_MAX = '1;
    localparam logic [logn-1:0] CNT_ONE = logn'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    // Reverse all logn bits of a sample index.
    function automatic logic [logn-1:0] f_bitrev(input logic [logn-1:0] a);
        logic [logn-1:0] r;
        r = '0;
        for (int i = 0; i < logn; i++) begin
            r[i] = a[logn-1-i];
        end
        return r;
    endfunction

    // Both banks live in one array; the bank select is the address MSB.
    logic [DW-1:0]           r_mem [0:2*N-1];

    logic                    r_wr_bank;
    logic [logn-1:0]         r_wr_cnt;
    logic [1:0]              r_full;

    state_t                  r_state;
    logic                    r_rd_bank;
    logic [logn-1:0]         r_rd_cnt;

    logic                    r_out_valid;
    logic                    r_out_last;
    logic [logn-1:0]         r_out_idx;
    logic [FLOAT_PRECISION-1:0] r_do_re;
    logic [FLOAT_PRECISION-1:0] r_do_im;

    logic                    w_wr_last;
    logic                    w_rd_issue;
    logic                    w_rd_last;
    logic [1:0]              w_full_set;
    logic [1:0]              w_full_clr;
    logic                    w_next_full;
    logic [logn-1:0]         w_rd_addr;
    logic [DW-1:0]           w_mem_q;

    assign w_wr_last  = in_valid && (r_wr_cnt == CNT_MAX);
    assign w_rd_issue = (r_state == S_READ);
    assign w_rd_last  = w_rd_issue && (r_rd_cnt == CNT_MAX);

    assign w_full_set = {w_wr_last &  r_wr_bank, w_wr_last & ~r_wr_bank};
    assign w_full_clr = {w_rd_last &  r_rd_bank, w_rd_last & ~r_rd_bank};

    // The bank the reader moves to may be completed on the very same edge as
    // the last read issue; counting that edge's set keeps frames bubble-free.
    assign w_next_full = r_full[~r_rd_bank] | w_full_set[~r_rd_bank];

    assign w_rd_addr = f_bitrev(r_rd_cnt);
    assign w_mem_q   = r_mem[{r_rd_bank, w_rd_addr}];

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_idx   = r_out_idx;
    assign do_re     = r_do_re;
    assign do_im     = r_do_im;

    // Store each incoming sample at its arrival (bit-reversed) position.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_mem[{r_wr_bank, r_wr_cnt}] <= {di_re, di_im};
        end
    end

    // Write pointer: count samples within the frame, swap banks at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
        end else if (in_valid) begin
            r_wr_cnt <= r_wr_cnt + CNT_ONE;
            if (w_wr_last) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // Bank full flags: set by the writer, cleared by the reader, set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_full_set[b]) begin
                    r_full[b] <= 1'b1;
                end else if (w_full_clr[b]) begin
                    r_full[b] <= 1'b0;
                end
            end
        end
    end

    // Read FSM with registered outputs; outputs are zero whenever not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rd_bank   <= 1'b0;
            r_rd_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_idx   <= '0;
            r_do_re     <= '0;
            r_do_im     <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_idx   <= '0;
            r_do_re     <= '0;
            r_do_im     <= '0;
            case (r_state)
                S_IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        r_state  <= S_READ;
                        r_rd_cnt <= '0;
                    end
                end
                S_READ: begin
                    r_out_valid <= 1'b1;
                    r_out_last  <= w_rd_last;
                    r_out_idx   <= r_rd_cnt;
                    r_do_re     <= w_mem_q[DW-1:FLOAT_PRECISION];
                    r_do_im     <= w_mem_q[FLOAT_PRECISION-1:0];
                    // Wraps to zero after the last issue, ready for the next bank.
                    r_rd_cnt    <= r_rd_cnt + CNT_ONE;
                    if (w_rd_last) begin
                        r_rd_bank <= ~r_rd_bank;
                        if (!w_next_full) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: a logn=8 instance driven through a table of
// frame patterns plus reset sequences, and a logn=3 instance for a small frame.
module tb_fft_bitrev_reorder;

    localparam int FP   = 64;
    localparam int LOGN = 8;
    localparam int N    = 256;
    localparam int N3   = 8;

    typedef struct {
        logic [63:0] re;
        logic [63:0] im;
        int          idx;
        logic        last;
    } exp_t;

    typedef struct {
        string name;
        int    frames;
        int    gap;
        int    pause;
        int    exp_count;
        int    exp_run;
        int    exp_lasts;
        int    exp_lat;
    } case_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [FP-1:0]   di_re, di_im;
    logic            out_valid, out_last;
    logic [LOGN-1:0] out_idx;
    logic [FP-1:0]   do_re, do_im;

    logic            in_valid3;
    logic [FP-1:0]   di_re3, di_im3;
    logic            out_valid3, out_last3;
    logic [2:0]      out_idx3;
    logic [FP-1:0]   do_re3, do_im3;

    exp_t  sb[$];
    exp_t  sb3[$];
    case_t cases[4];

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    int out_count, last_count, run, max_run, first_cyc, last_acc;
    int out3_count, last3_count;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_bitrev_reorder #(.FLOAT_PRECISION(FP), .logn(LOGN)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .di_re(di_re), .di_im(di_im),
        .out_valid(out_valid), .out_last(out_last), .out_idx(out_idx),
        .do_re(do_re), .do_im(do_im)
    );

    fft_bitrev_reorder #(.FLOAT_PRECISION(FP), .logn(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .di_re(di_re3), .di_im(di_im3),
        .out_valid(out_valid3), .out_last(out_last3), .out_idx(out_idx3),
        .do_re(do_re3), .do_im(do_im3)
    );

    function automatic int bitrev(input int v, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            if (v[i]) r = r | (1 << (bits - 1 - i));
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon();
        exp_t e;
        if (out_valid) begin
            out_count++;
            run++;
            if (out_last) last_count++;
            if (first_cyc < 0) first_cyc = cyc;
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: out_valid=1 idx=%0d re=%0d with nothing expected", out_idx, do_re);
            end else begin
                e = sb.pop_front();
                chk("do_re", do_re, e.re);
                chk("do_im", do_im, e.im);
                chk("out_idx", 64'(out_idx), 64'(e.idx));
                chk("out_last", 64'(out_last), 64'(e.last));
            end
        end else begin
            if (run > max_run) max_run = run;
            run = 0;
            chk("idle_zero", 64'(|{do_re, do_im, out_idx, out_last}), 64'd0);
        end
        if (out_valid3) begin
            out3_count++;
            if (out_last3) last3_count++;
            if (sb3.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output3: out_valid=1 idx=%0d with nothing expected", out_idx3);
            end else begin
                e = sb3.pop_front();
                chk("do_re3", do_re3, e.re);
                chk("do_im3", do_im3, e.im);
                chk("out_idx3", 64'(out_idx3), 64'(e.idx));
                chk("out_last3", 64'(out_last3), 64'(e.last));
            end
        end else begin
            chk("idle_zero3", 64'(|{do_re3, do_im3, out_idx3, out_last3}), 64'd0);
        end
    endtask

    task automatic step(input logic v, input logic [63:0] re, input logic [63:0] im);
        @(posedge clk);
        #1;
        in_valid  = v;
        di_re     = v ? re : 64'd0;
        di_im     = v ? im : 64'd0;
        in_valid3 = 1'b0;
        di_re3    = 64'd0;
        di_im3    = 64'd0;
        @(negedge clk);
        mon();
    endtask

    task automatic step3(input logic v, input logic [63:0] re, input logic [63:0] im);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        di_re     = 64'd0;
        di_im     = 64'd0;
        in_valid3 = v;
        di_re3    = v ? re : 64'd0;
        di_im3    = v ? im : 64'd0;
        @(negedge clk);
        mon();
    endtask

    // Sends one frame in bit-reversed order; expected natural-order output is
    // queued when the last sample is driven.
    task automatic send_frame(input int base, input int gap, input bit rec);
        exp_t e;
        int   b;
        for (int i = 0; i < N; i++) begin
            if (i > 0) repeat (gap) step(1'b0, 64'd0, 64'd0);
            b = bitrev(i, LOGN);
            if (i == N - 1) begin
                for (int j = 0; j < N; j++) begin
                    e.re   = 64'(base + j);
                    e.im   = 64'(1000 + base + j);
                    e.idx  = j;
                    e.last = (j == N - 1);
                    sb.push_back(e);
                end
            end
            step(1'b1, 64'(base + b), 64'(1000 + base + b));
            if (i == N - 1 && rec) last_acc = cyc + 1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || sb3.size() != 0 || out_valid || out_valid3) && t < 3000) begin
            step(1'b0, 64'd0, 64'd0);
            t++;
        end
        chk("drain_done", 64'(sb.size() + sb3.size()), 64'd0);
        repeat (4) step(1'b0, 64'd0, 64'd0);
    endtask

    task automatic clear_stats();
        out_count   = 0;
        last_count  = 0;
        run         = 0;
        max_run     = 0;
        first_cyc   = -1;
        last_acc    = 0;
        out3_count  = 0;
        last3_count = 0;
    endtask

    initial begin
        exp_t e;
        int   ord3[N3];

        cases[0] = '{"single",      1, 0, 0,  256, 256, 1, 2};
        cases[1] = '{"back2back",   2, 0, 0,  512, 512, 2, 2};
        cases[2] = '{"gapped",      1, 1, 0,  256, 256, 1, 2};
        cases[3] = '{"overlap",     2, 0, 10, 512, 256, 2, 2};
        ord3     = '{0, 4, 2, 6, 1, 5, 3, 7};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        di_re     = '0;
        di_im     = '0;
        in_valid3 = 1'b0;
        di_re3    = '0;
        di_im3    = '0;
        clear_stats();

        repeat (3) step(1'b0, 64'd0, 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_idx", 64'(out_idx), 64'd0);
        chk("reset_do_re", do_re, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        mon();

        for (int c = 0; c < 4; c++) begin
            clear_stats();
            for (int f = 0; f < cases[c].frames; f++) begin
                if (f > 0) repeat (cases[c].pause) step(1'b0, 64'd0, 64'd0);
                send_frame(f * N, cases[c].gap, f == 0);
            end
            drain();
            chk({cases[c].name, "_count"}, 64'(out_count), 64'(cases[c].exp_count));
            chk({cases[c].name, "_run"}, 64'(max_run), 64'(cases[c].exp_run));
            chk({cases[c].name, "_lasts"}, 64'(last_count), 64'(cases[c].exp_lasts));
            chk({cases[c].name, "_latency"}, 64'(first_cyc - last_acc), 64'(cases[c].exp_lat));
        end

        // Reset after a partial frame: the 100 samples must never appear.
        clear_stats();
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 64'(bitrev(i, LOGN)), 64'(1000 + bitrev(i, LOGN)));
        end
        repeat (20) step(1'b0, 64'd0, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) step(1'b0, 64'd0, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        mon();
        clear_stats();
        send_frame(0, 0, 1'b1);
        drain();
        chk("partial_rst_count", 64'(out_count), 64'd256);
        chk("partial_rst_latency", 64'(first_cyc - last_acc), 64'd2);

        // Asynchronous reset in the middle of reading a frame.
        clear_stats();
        send_frame(0, 0, 1'b1);
        repeat (50) step(1'b0, 64'd0, 64'd0);
        chk("midread_active", 64'(out_valid), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_data", 64'(|{do_re, do_im, out_idx, out_last}), 64'd0);
        sb.delete();
        run = 0;
        repeat (3) step(1'b0, 64'd0, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        mon();
        clear_stats();
        send_frame(256, 0, 1'b1);
        drain();
        chk("midread_rst_count", 64'(out_count), 64'd256);
        chk("midread_rst_lasts", 64'(last_count), 64'd1);
        chk("midread_rst_latency", 64'(first_cyc - last_acc), 64'd2);

        // logn=3 instance: bit-reversed 0,4,2,6,1,5,3,7 comes out as 0..7.
        clear_stats();
        for (int i = 0; i < N3; i++) begin
            if (i == N3 - 1) begin
                for (int j = 0; j < N3; j++) begin
                    e.re   = 64'(j);
                    e.im   = 64'(1000 + j);
                    e.idx  = j;
                    e.last = (j == N3 - 1);
                    sb3.push_back(e);
                end
            end
            step3(1'b1, 64'(ord3[i]), 64'(1000 + ord3[i]));
        end
        drain();
        chk("n3_count", 64'(out3_count), 64'd8);
        chk("n3_lasts", 64'(last3_count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
